// File: rtl/music_pkg.sv
// -----------------------------------------------------------------------------
// music_pkg
// Shared definitions for the note record/playback path.
//   state_t  : sequencer states (IDLE, HOLD, PLAY_TONE, PLAY_GAP)
//   pitch_t  : {note, octave} as stored in the buffer and driven to the datapath
//   NOTE_W / OCT_W / PITCH_W : field widths of a buffer entry
//                              (entry = {pitch_t, dur}, dur in the LSBs)
//   NOTE_MAX : highest valid note code (0..11)
// -----------------------------------------------------------------------------
package music_pkg;

   localparam int NOTE_W   = 4;
   localparam int OCT_W    = 2;
   localparam int PITCH_W  = NOTE_W + OCT_W;
   localparam int NOTE_MAX = 11;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HOLD      = 2'd1,
      PLAY_TONE = 2'd2,
      PLAY_GAP  = 2'd3
   } state_t;

   typedef struct packed {
      logic [NOTE_W-1:0] note;
      logic [OCT_W-1:0]  octave;
   } pitch_t;

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to a timing tick. The counter runs 0..TICK_DIV-1 and tick
// is high while it sits at TICK_DIV-1. clr restarts the count from 0 so a new
// timing segment always gets a full first tick period.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-low reset
//   clr   in  restart the count (takes effect on the next edge)
//   tick  out one-cycle tick, suppressed while clr is asserted
// -----------------------------------------------------------------------------
module tick_prescaler #(
   parameter int TICK_DIV = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
// Record/playback controller between the keyboard decoder and the datapath.
// Live: the held key is forwarded with tone_on=1 and, on release, logged as
// {note, octave, held ticks}. On play_req the log is replayed in order, each
// note for its recorded duration followed by GAP_TICKS of silence.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   note_start/note_stop  key make / break pulses (note_in/octave_in valid on make)
//   play_req              start playback from IDLE, abort while playing
//   clear_req             empty the buffer
//   note_out/octave_out   pitch to the datapath (held while tone_on=0)
//   tone_on               1 = sound note_out
//   playing               1 in PLAY_TONE / PLAY_GAP
//   full, count           buffer status
// -----------------------------------------------------------------------------
module note_sequencer
   import music_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int DUR_W     = 8,
   parameter int TICK_DIV  = 500000,
   parameter int GAP_TICKS = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     note_start,
   input  logic                     note_stop,
   input  logic [NOTE_W-1:0]        note_in,
   input  logic [OCT_W-1:0]         octave_in,
   input  logic                     play_req,
   input  logic                     clear_req,
   output logic [NOTE_W-1:0]        note_out,
   output logic [OCT_W-1:0]         octave_out,
   output logic                     tone_on,
   output logic                     playing,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW      = $clog2(DEPTH);
   localparam int CW      = AW + 1;
   localparam int ENTRY_W = PITCH_W + DUR_W;

   localparam logic [DUR_W-1:0] DUR_SAT  = {DUR_W{1'b1}};
   localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
   localparam logic [DUR_W-1:0] GAP_CNT  = DUR_W'(GAP_TICKS);
   localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

   state_t               state;
   logic [DUR_W-1:0]     dur;        // ticks the live key has been held
   logic [DUR_W-1:0]     seg_ticks;  // ticks elapsed in the current play segment
   logic [DUR_W-1:0]     play_dur;   // recorded duration of the note being played
   logic [AW-1:0]        rd_ptr;
   logic [AW-1:0]        rd_next;
   logic [AW-1:0]        rd_idx;
   logic [ENTRY_W-1:0]   mem [DEPTH];
   logic [ENTRY_W-1:0]   rd_entry;
   logic [ENTRY_W-1:0]   commit_entry;
   pitch_t               rd_pitch;
   logic [CW-1:0]        count_inc;
   logic                 commit_en;
   logic                 tick;
   logic                 tick_clr;

   // The prescaler is parked at 0 throughout IDLE, so every segment entered
   // from IDLE starts with a full tick period. A new key in HOLD restarts it
   // too. Tone->gap->tone transitions happen on a tick, where the counter
   // wraps to 0 by itself, so those need no explicit clear.
   assign tick_clr = (state == IDLE) || (state == HOLD && note_start);

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clr   (tick_clr),
      .tick  (tick)
   );

   // A commit happens whenever the live note ends (release or new key),
   // unless a clear wins that cycle or the buffer has no room.
   assign commit_en    = (state == HOLD) && !clear_req && (note_start || note_stop) && !full;
   assign commit_entry = {note_out, octave_out, (dur == '0) ? DUR_ONE : dur};
   assign count_inc    = count + 1'b1;

   // Read port feeds whichever entry the FSM will load next: entry 0 when
   // playback starts from IDLE, otherwise the one after rd_ptr.
   assign rd_next  = rd_ptr + 1'b1;
   assign rd_idx   = (state == IDLE) ? '0 : rd_next;
   assign rd_entry = mem[rd_idx];
   assign rd_pitch = rd_entry[ENTRY_W-1 -: PITCH_W];

   // Buffer contents need no reset; only the count decides what is valid.
   always_ff @(posedge clk) begin
      if (commit_en) begin
         mem[count[AW-1:0]] <= commit_entry;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         note_out   <= '0;
         octave_out <= '0;
         tone_on    <= 1'b0;
         playing    <= 1'b0;
         full       <= 1'b0;
         count      <= '0;
         rd_ptr     <= '0;
         dur        <= '0;
         seg_ticks  <= '0;
         play_dur   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (clear_req) begin
                  count <= '0;
                  full  <= 1'b0;
               end else if (play_req && count != '0) begin
                  state      <= PLAY_TONE;
                  rd_ptr     <= '0;
                  seg_ticks  <= '0;
                  play_dur   <= rd_entry[DUR_W-1:0];
                  note_out   <= rd_pitch.note;
                  octave_out <= rd_pitch.octave;
                  tone_on    <= 1'b1;
                  playing    <= 1'b1;
               end else if (note_start) begin
                  state      <= HOLD;
                  note_out   <= note_in;
                  octave_out <= octave_in;
                  dur        <= '0;
                  tone_on    <= 1'b1;
               end
            end

            HOLD: begin
               if (clear_req) begin
                  state   <= IDLE;
                  count   <= '0;
                  full    <= 1'b0;
                  tone_on <= 1'b0;
               end else begin
                  if (commit_en) begin
                     count <= count_inc;
                     full  <= (count_inc == FULL_CNT);
                  end
                  if (note_start) begin
                     note_out   <= note_in;
                     octave_out <= octave_in;
                     dur        <= '0;
                  end else if (note_stop) begin
                     state   <= IDLE;
                     tone_on <= 1'b0;
                  end else if (tick && dur != DUR_SAT) begin
                     dur <= dur + 1'b1;
                  end
               end
            end

            PLAY_TONE: begin
               if (play_req) begin
                  state     <= IDLE;
                  tone_on   <= 1'b0;
                  playing   <= 1'b0;
                  seg_ticks <= '0;
               end else if (tick) begin
                  if (seg_ticks + 1'b1 == play_dur) begin
                     state     <= PLAY_GAP;
                     tone_on   <= 1'b0;
                     seg_ticks <= '0;
                  end else begin
                     seg_ticks <= seg_ticks + 1'b1;
                  end
               end
            end

            PLAY_GAP: begin
               if (play_req) begin
                  state     <= IDLE;
                  playing   <= 1'b0;
                  seg_ticks <= '0;
               end else if (tick) begin
                  if (seg_ticks + 1'b1 == GAP_CNT) begin
                     seg_ticks <= '0;
                     if ({1'b0, rd_ptr} == count - 1'b1) begin
                        state   <= IDLE;
                        playing <= 1'b0;
                     end else begin
                        state      <= PLAY_TONE;
                        rd_ptr     <= rd_next;
                        play_dur   <= rd_entry[DUR_W-1:0];
                        note_out   <= rd_pitch.note;
                        octave_out <= rd_pitch.octave;
                        tone_on    <= 1'b1;
                     end
                  end else begin
                     seg_ticks <= seg_ticks + 1'b1;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
// Self-checking bench for note_sequencer (DEPTH=4, DUR_W=8, TICK_DIV=4,
// GAP_TICKS=2). Recorded notes push their expected pitch and tone length onto
// a scoreboard queue; playback pops and compares them as the DUT plays.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_note_sequencer;
   import music_pkg::*;

   localparam int DEPTH     = 4;
   localparam int DUR_W     = 8;
   localparam int TICK_DIV  = 4;
   localparam int GAP_TICKS = 2;
   localparam int GAP_CYC   = GAP_TICKS * TICK_DIV;
   localparam int DUR_MAX   = 255;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       note_start = 1'b0;
   logic       note_stop = 1'b0;
   logic [3:0] note_in = '0;
   logic [1:0] octave_in = '0;
   logic       play_req = 1'b0;
   logic       clear_req = 1'b0;
   logic [3:0] note_out;
   logic [1:0] octave_out;
   logic       tone_on;
   logic       playing;
   logic       full;
   logic [2:0] count;

   typedef struct {
      int note;
      int oct;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   model_count = 0;

   note_sequencer #(
      .DEPTH     (DEPTH),
      .DUR_W     (DUR_W),
      .TICK_DIV  (TICK_DIV),
      .GAP_TICKS (GAP_TICKS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .note_start (note_start),
      .note_stop  (note_stop),
      .note_in    (note_in),
      .octave_in  (octave_in),
      .play_req   (play_req),
      .clear_req  (clear_req),
      .note_out   (note_out),
      .octave_out (octave_out),
      .tone_on    (tone_on),
      .playing    (playing),
      .full       (full),
      .count      (count)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1);
   end

   // ---------------- stimulus primitives (called at a falling edge) -----------
   task automatic pulse_start(input int n, input int o);
      note_start = 1'b1;
      note_in    = 4'(n);
      octave_in  = 2'(o);
      @(negedge clk);
      note_start = 1'b0;
   endtask

   task automatic pulse_stop();
      note_stop = 1'b1;
      @(negedge clk);
      note_stop = 1'b0;
   endtask

   task automatic pulse_play();
      play_req = 1'b1;
      @(negedge clk);
      play_req = 1'b0;
   endtask

   task automatic clear_all();
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      model_count = 0;
      sb.delete();
   endtask

   // Key held for h cycles between make and break edges -> floor(h/TICK_DIV)
   // ticks, stored as at least 1 and at most DUR_MAX.
   task automatic push_expected(input int n, input int o, input int h);
      int d;
      d = h / TICK_DIV;
      if (d < 1) d = 1;
      if (d > DUR_MAX) d = DUR_MAX;
      if (model_count < DEPTH) begin
         sb.push_back('{note: n, oct: o, cyc: d * TICK_DIV});
         model_count++;
      end
   endtask

   task automatic record(input int n, input int o, input int h);
      pulse_start(n, o);
      repeat (h) @(negedge clk);
      pulse_stop();
      push_expected(n, o, h);
      $display("record note=%0d oct=%0d held=%0d cycles count=%0d", n, o, h, count);
   endtask

   // Scoreboard consumer: pops n entries while the DUT plays them back.
   task automatic drain_playback(input int n);
      exp_t       e;
      int         hi;
      int         lo;
      logic [3:0] nt;
      logic [1:0] oc;
      for (int i = 0; i < n; i++) begin
         if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_underflow: entry %0d has no expected value", i);
            break;
         end
         e  = sb.pop_front();
         nt = note_out;
         oc = octave_out;
         hi = 0;
         while (tone_on === 1'b1 && hi < 4000) begin
            hi++;
            @(negedge clk);
         end
         lo = 0;
         while (tone_on !== 1'b1 && playing === 1'b1 && lo < 200) begin
            lo++;
            @(negedge clk);
         end
         $display("play %0d: note=%0d oct=%0d tone=%0d gap=%0d", i, nt, oc, hi, lo);
         n_cmp++;
         if (hi !== e.cyc) begin
            n_bad++;
            $display("FAIL play_len[%0d]: got %0d cycles, required %0d", i, hi, e.cyc);
         end
         n_cmp++;
         if (nt !== 4'(e.note) || oc !== 2'(e.oct)) begin
            n_bad++;
            $display("FAIL play_pitch[%0d]: got %0d/%0d, required %0d/%0d",
                     i, nt, oc, e.note, e.oct);
         end
         n_cmp++;
         if (lo !== GAP_CYC) begin
            n_bad++;
            $display("FAIL play_gap[%0d]: got %0d cycles, required %0d", i, lo, GAP_CYC);
         end
      end
      n_cmp++;
      if (playing !== 1'b0 || tone_on !== 1'b0) begin
         n_bad++;
         $display("FAIL play_end: playing=%0b tone_on=%0b, required 0/0", playing, tone_on);
      end
   endtask

   // ---------------- scenarios ------------------------------------------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++;
      if (tone_on !== 1'b0 || playing !== 1'b0 || full !== 1'b0 || count !== 3'd0 ||
          note_out !== 4'd0 || octave_out !== 2'd0) begin
         n_bad++;
         $display("FAIL reset_state: tone=%0b play=%0b full=%0b count=%0d note=%0d oct=%0d, required all 0",
                  tone_on, playing, full, count, note_out, octave_out);
      end
      reset = 1'b1;
      @(negedge clk);
      $display("reset released");
   endtask

   task automatic test_record();
      clear_all();
      record(3, 1, 13);
      n_cmp++;
      if (count !== 3'd1) begin
         n_bad++;
         $display("FAIL record_count1: got %0d, required 1", count);
      end
      record(5, 0, 0);
      n_cmp++;
      if (count !== 3'd2 || tone_on !== 1'b0) begin
         n_bad++;
         $display("FAIL record_count2: got count=%0d tone=%0b, required 2/0", count, tone_on);
      end
      pulse_play();
      drain_playback(2);
   endtask

   task automatic test_playback();
      clear_all();
      record(3, 1, 13);
      record(7, 2, 9);
      pulse_play();
      n_cmp++;
      if (playing !== 1'b1) begin
         n_bad++;
         $display("FAIL playback_start: playing=%0b, required 1", playing);
      end
      drain_playback(2);
   endtask

   task automatic test_full();
      clear_all();
      for (int i = 0; i < DEPTH; i++) begin
         record((i * 5) % (NOTE_MAX + 1), i % 4, 4 + i * 4);
      end
      pulse_start(11, 3);
      repeat (5) @(negedge clk);
      n_cmp++;
      if (tone_on !== 1'b1 || note_out !== 4'd11 || octave_out !== 2'd3) begin
         n_bad++;
         $display("FAIL full_live: tone=%0b note=%0d oct=%0d, required 1/11/3",
                  tone_on, note_out, octave_out);
      end
      n_cmp++;
      if (count !== 3'd4 || full !== 1'b1) begin
         n_bad++;
         $display("FAIL full_flag: count=%0d full=%0b, required 4/1", count, full);
      end
      pulse_stop();
      push_expected(11, 3, 5);
      n_cmp++;
      if (count !== 3'd4 || full !== 1'b1) begin
         n_bad++;
         $display("FAIL full_after_stop: count=%0d full=%0b, required 4/1", count, full);
      end
      pulse_play();
      drain_playback(4);
   endtask

   task automatic test_abort();
      clear_all();
      record(2, 1, 8);
      record(4, 2, 8);
      pulse_play();
      // entry 0: 8 high + 8 gap, so 19 edges later entry 1 is sounding
      repeat (19) @(negedge clk);
      n_cmp++;
      if (tone_on !== 1'b1 || note_out !== 4'd4) begin
         n_bad++;
         $display("FAIL abort_pre: tone=%0b note=%0d, required 1/4", tone_on, note_out);
      end
      pulse_play();
      n_cmp++;
      if (tone_on !== 1'b0 || playing !== 1'b0 || count !== 3'd2) begin
         n_bad++;
         $display("FAIL abort: tone=%0b playing=%0b count=%0d, required 0/0/2",
                  tone_on, playing, count);
      end
      sb.delete();
      repeat (10) @(negedge clk);
      n_cmp++;
      if (tone_on !== 1'b0 || playing !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_stays_idle: tone=%0b playing=%0b, required 0/0", tone_on, playing);
      end
      // clear and play together: clear wins, nothing left to play
      clear_req = 1'b1;
      play_req  = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      play_req  = 1'b0;
      model_count = 0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (count !== 3'd0 || playing !== 1'b0 || tone_on !== 1'b0) begin
         n_bad++;
         $display("FAIL clear_play: count=%0d playing=%0b tone=%0b, required 0/0/0",
                  count, playing, tone_on);
      end
      $display("abort and clear+play done count=%0d", count);
   endtask

   task automatic test_chain_and_saturate();
      clear_all();
      pulse_start(1, 0);
      repeat (9) @(negedge clk);
      pulse_start(9, 3);
      push_expected(1, 0, 9);
      n_cmp++;
      if (note_out !== 4'd9 || octave_out !== 2'd3 || tone_on !== 1'b1 || count !== 3'd1) begin
         n_bad++;
         $display("FAIL chain: note=%0d oct=%0d tone=%0b count=%0d, required 9/3/1/1",
                  note_out, octave_out, tone_on, count);
      end
      repeat (1205) @(negedge clk);
      pulse_stop();
      push_expected(9, 3, 1205);
      n_cmp++;
      if (count !== 3'd2) begin
         n_bad++;
         $display("FAIL chain_count: got %0d, required 2", count);
      end
      pulse_play();
      drain_playback(2);
   endtask

   task automatic test_reset_mid_hold();
      clear_all();
      record(8, 1, 4);
      pulse_start(6, 2);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (tone_on !== 1'b1 || count !== 3'd1) begin
         n_bad++;
         $display("FAIL mid_hold_pre: tone=%0b count=%0d, required 1/1", tone_on, count);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (tone_on !== 1'b0 || count !== 3'd0 || playing !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_reset_async: tone=%0b count=%0d playing=%0b, required 0/0/0",
                  tone_on, count, playing);
      end
      @(negedge clk);
      reset = 1'b1;
      model_count = 0;
      sb.delete();
      repeat (2) @(negedge clk);
      n_cmp++;
      if (tone_on !== 1'b0 || count !== 3'd0 || playing !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_reset_after: tone=%0b count=%0d playing=%0b, required 0/0/0",
                  tone_on, count, playing);
      end
      $display("mid-hold reset done");
   endtask

   initial begin
      test_reset();
      test_record();
      test_playback();
      test_full();
      test_abort();
      test_chain_and_saturate();
      test_reset_mid_hold();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
